// File: rtl/store_buffer.sv
// Store buffer: in-order circular queue of resolved stores. Entries are
// allocated at the tail, marked committed in order by the ROB, drained to
// memory from the head, and uncommitted entries are discarded on a flush.
// Loads may forward data from the youngest buffered store to the same address.
module store_buffer #(
    parameter int SB_ENTRY    = 8,
    parameter int WORD_SIZE_P = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   exe_sb_valid_i,
    input  logic [WORD_SIZE_P-1:0] exe_sb_addr_i,
    input  logic [WORD_SIZE_P-1:0] exe_sb_data_i,
    output logic                   sb_exe_ready_o,
    input  logic                   rob_sb_valid_i,
    input  logic                   rob_mispredict_i,
    output logic                   sb_mem_valid_o,
    output logic [WORD_SIZE_P-1:0] sb_mem_addr_o,
    output logic [WORD_SIZE_P-1:0] sb_mem_data_o,
    input  logic                   mem_sb_ready_i,
    input  logic [WORD_SIZE_P-1:0] ld_addr_i,
    output logic                   sb_ld_hit_o,
    output logic [WORD_SIZE_P-1:0] sb_ld_data_o,
    output logic                   sb_empty_o
);

    localparam int PW = $clog2(SB_ENTRY);
    localparam int CW = PW + 1;

    logic [SB_ENTRY-1:0]    valid_q, valid_d;
    logic [SB_ENTRY-1:0]    cmtd_q, cmtd_d;
    logic [WORD_SIZE_P-1:0] addr_q [SB_ENTRY];
    logic [WORD_SIZE_P-1:0] addr_d [SB_ENTRY];
    logic [WORD_SIZE_P-1:0] data_q [SB_ENTRY];
    logic [WORD_SIZE_P-1:0] data_d [SB_ENTRY];
    logic [PW-1:0]          head_q, head_d;
    logic [PW-1:0]          cmt_q, cmt_d;
    logic [PW-1:0]          tail_q, tail_d;
    logic [CW-1:0]          count_q, count_d;

    logic                   alloc_s;
    logic                   commit_s;
    logic                   drain_s;
    logic                   hit_s;
    logic [WORD_SIZE_P-1:0] fwd_data_s;
    logic [PW-1:0]          fwd_idx_s;

    // Number of set bits in an entry mask.
    function automatic logic [CW-1:0] popcount(input logic [SB_ENTRY-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < SB_ENTRY; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    // Ready depends only on registered occupancy and the flush request.
    assign sb_exe_ready_o = (count_q != CW'(SB_ENTRY)) & ~rob_mispredict_i;
    assign sb_mem_valid_o = valid_q[head_q] & cmtd_q[head_q];
    assign sb_mem_addr_o  = addr_q[head_q];
    assign sb_mem_data_o  = data_q[head_q];
    assign sb_empty_o     = (count_q == CW'(0));
    assign sb_ld_hit_o    = hit_s;
    assign sb_ld_data_o   = fwd_data_s;

    // The oldest uncommitted entry, if any, always sits at the commit pointer.
    assign alloc_s  = exe_sb_valid_i & sb_exe_ready_o;
    assign commit_s = rob_sb_valid_i & valid_q[cmt_q] & ~cmtd_q[cmt_q];
    assign drain_s  = sb_mem_valid_o & mem_sb_ready_i;

    // Next-state for entries, pointers and occupancy.
    always_comb begin
        valid_d = valid_q;
        cmtd_d  = cmtd_q;
        addr_d  = addr_q;
        data_d  = data_q;
        head_d  = head_q;
        cmt_d   = cmt_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (alloc_s) begin
            valid_d[tail_q] = 1'b1;
            cmtd_d[tail_q]  = 1'b0;
            addr_d[tail_q]  = exe_sb_addr_i;
            data_d[tail_q]  = exe_sb_data_i;
            tail_d          = tail_q + PW'(1);
        end else begin
            tail_d = tail_q;
        end

        if (commit_s) begin
            cmtd_d[cmt_q] = 1'b1;
            cmt_d         = cmt_q + PW'(1);
        end else begin
            cmt_d = cmt_q;
        end

        if (drain_s) begin
            valid_d[head_q] = 1'b0;
            cmtd_d[head_q]  = 1'b0;
            head_d          = head_q + PW'(1);
        end else begin
            head_d = head_q;
        end

        // A flush keeps only committed entries (including one committed this
        // cycle); alloc is already blocked because ready is low.
        if (rob_mispredict_i) begin
            valid_d = valid_d & cmtd_d;
            tail_d  = cmt_d;
            count_d = popcount(valid_d);
        end else begin
            count_d = count_q + CW'(alloc_s) - CW'(drain_s);
        end
    end

    // Load forwarding: scan oldest to youngest so the youngest match wins.
    always_comb begin
        hit_s      = 1'b0;
        fwd_data_s = '0;
        fwd_idx_s  = '0;
        for (int i = 0; i < SB_ENTRY; i++) begin
            fwd_idx_s = head_q + PW'(i);
            if (valid_q[fwd_idx_s] && (addr_q[fwd_idx_s] == ld_addr_i)) begin
                hit_s      = 1'b1;
                fwd_data_s = data_q[fwd_idx_s];
            end else begin
                hit_s      = hit_s;
                fwd_data_s = fwd_data_s;
            end
        end
    end

    // State registers; reset discards every entry, committed or not.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            valid_q <= '0;
            cmtd_q  <= '0;
            head_q  <= '0;
            cmt_q   <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < SB_ENTRY; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            cmtd_q  <= cmtd_d;
            head_q  <= head_d;
            cmt_q   <= cmt_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Testbench for store_buffer: directed scenarios plus randomized traffic,
// checked against a queue-based model of the buffered stores.
module tb_store_buffer;

    localparam int N = 8;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         exe_v = 1'b0;
    logic [W-1:0] exe_a = '0;
    logic [W-1:0] exe_d = '0;
    logic         ready;
    logic         rob_v = 1'b0;
    logic         mispred = 1'b0;
    logic         mvalid;
    logic [W-1:0] maddr;
    logic [W-1:0] mdata;
    logic         mem_rdy = 1'b0;
    logic [W-1:0] ld_a = '0;
    logic         hit;
    logic [W-1:0] ldata;
    logic         empty;

    int ncmp  = 0;
    int nfail = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] d;
    } ent_t;
    ent_t mq[$];     // buffered stores, oldest first
    int   ncomm = 0; // committed stores form a prefix of mq

    store_buffer #(.SB_ENTRY(N), .WORD_SIZE_P(W)) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .exe_sb_valid_i(exe_v), .exe_sb_addr_i(exe_a), .exe_sb_data_i(exe_d),
        .sb_exe_ready_o(ready),
        .rob_sb_valid_i(rob_v), .rob_mispredict_i(mispred),
        .sb_mem_valid_o(mvalid), .sb_mem_addr_o(maddr), .sb_mem_data_o(mdata),
        .mem_sb_ready_i(mem_rdy),
        .ld_addr_i(ld_a), .sb_ld_hit_o(hit), .sb_ld_data_o(ldata),
        .sb_empty_o(empty)
    );

    always #5 clk = ~clk;

    function automatic logic exp_ready();
        return (mq.size() != N) && !mispred;
    endfunction

    function automatic logic exp_mvalid();
        return ncomm > 0;
    endfunction

    function automatic logic exp_hit();
        for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].a == ld_a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [W-1:0] exp_ldata();
        for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].a == ld_a) return mq[i].d;
        return 16'h0000;
    endfunction

    task automatic idle();
        exe_v = 1'b0; rob_v = 1'b0; mispred = 1'b0; mem_rdy = 1'b0;
    endtask

    // Advance one clock, applying the current inputs to the model.
    task automatic tick();
        int sz;
        bit c, d, a;
        sz = mq.size();
        c  = rob_v && (ncomm < sz);
        d  = (ncomm > 0) && mem_rdy;
        a  = exe_v && (sz != N) && !mispred;
        @(posedge clk);
        if (d) begin mq.delete(0); ncomm--; end
        if (c) ncomm++;
        if (mispred) begin
            while (mq.size() > ncomm) mq.delete(mq.size() - 1);
        end else if (a) begin
            mq.push_back('{exe_a, exe_d});
        end
        #1;
    endtask

    task automatic alloc(input logic [W-1:0] a, input logic [W-1:0] d);
        exe_v = 1'b1; exe_a = a; exe_d = d;
        tick();
        exe_v = 1'b0;
    endtask

    task automatic test_reset();
        idle(); ld_a = 16'h0000;
        #12;
        ncmp++; if (mvalid !== 1'b0) begin nfail++; $display("FAIL rst_mvalid got %b want 0", mvalid); end
        ncmp++; if (hit !== 1'b0) begin nfail++; $display("FAIL rst_hit got %b want 0", hit); end
        ncmp++; if (ldata !== 16'h0000) begin nfail++; $display("FAIL rst_ldata got %h want 0000", ldata); end
        ncmp++; if (empty !== 1'b1) begin nfail++; $display("FAIL rst_empty got %b want 1", empty); end
        ncmp++; if (ready !== 1'b1) begin nfail++; $display("FAIL rst_ready got %b want 1", ready); end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        alloc(16'h0010, 16'hAAAA);
        rob_v = 1'b1; tick(); rob_v = 1'b0;
        mem_rdy = 1'b1; #3;
        ncmp++; if (mvalid !== 1'b1) begin nfail++; $display("FAIL basic_mvalid got %b want 1", mvalid); end
        ncmp++; if (maddr !== 16'h0010) begin nfail++; $display("FAIL basic_addr got %h want 0010", maddr); end
        ncmp++; if (mdata !== 16'hAAAA) begin nfail++; $display("FAIL basic_data got %h want aaaa", mdata); end
        tick(); mem_rdy = 1'b0; #3;
        ncmp++; if (empty !== 1'b1) begin nfail++; $display("FAIL basic_empty got %b want 1", empty); end
        ncmp++; if (mvalid !== 1'b0) begin nfail++; $display("FAIL basic_mvalid_after got %b want 0", mvalid); end
    endtask

    task automatic test_full();
        idle();
        for (int i = 0; i < N; i++) begin
            exe_v = 1'b1; exe_a = 16'h0200 + 16'(i); exe_d = 16'h5000 + 16'(i); #3;
            ncmp++; if (ready !== 1'b1) begin nfail++; $display("FAIL full_ready_%0d got %b want 1", i, ready); end
            tick();
        end
        exe_v = 1'b1; exe_a = 16'h0300; exe_d = 16'hDEAD; #3;
        ncmp++; if (ready !== 1'b0) begin nfail++; $display("FAIL full_ready_at8 got %b want 0", ready); end
        tick(); exe_v = 1'b0; ld_a = 16'h0300; #3;
        ncmp++; if (hit !== 1'b0) begin nfail++; $display("FAIL full_no_overwrite got %b want 0", hit); end
        rob_v = 1'b1; tick(); rob_v = 1'b0;
        mem_rdy = 1'b1; #3;
        ncmp++; if (maddr !== 16'h0200) begin nfail++; $display("FAIL full_drain_addr got %h want 0200", maddr); end
        tick(); mem_rdy = 1'b0; #3;
        ncmp++; if (ready !== 1'b1) begin nfail++; $display("FAIL full_ready_after got %b want 1", ready); end
        mispred = 1'b1; #1;
        ncmp++; if (ready !== 1'b0) begin nfail++; $display("FAIL full_ready_flush got %b want 0", ready); end
        tick(); mispred = 1'b0; #3;
        ncmp++; if (empty !== 1'b1) begin nfail++; $display("FAIL full_flush_empty got %b want 1", empty); end
    endtask

    task automatic test_forward();
        idle();
        alloc(16'h0020, 16'h1111);
        alloc(16'h0020, 16'h2222);
        ld_a = 16'h0020; #3;
        ncmp++; if (hit !== 1'b1) begin nfail++; $display("FAIL fwd_hit got %b want 1", hit); end
        ncmp++; if (ldata !== 16'h2222) begin nfail++; $display("FAIL fwd_data got %h want 2222", ldata); end
        ld_a = 16'h0030; #1;
        ncmp++; if (hit !== 1'b0) begin nfail++; $display("FAIL fwd_miss_hit got %b want 0", hit); end
        ncmp++; if (ldata !== 16'h0000) begin nfail++; $display("FAIL fwd_miss_data got %h want 0000", ldata); end
        mispred = 1'b1; tick(); mispred = 1'b0;
    endtask

    task automatic test_flush();
        idle();
        alloc(16'h0100, 16'h0001);
        alloc(16'h0101, 16'h0002);
        alloc(16'h0102, 16'h0003);
        rob_v = 1'b1; tick(); rob_v = 1'b0;
        mispred = 1'b1; tick(); mispred = 1'b0;
        ld_a = 16'h0102; #3;
        ncmp++; if (hit !== 1'b0) begin nfail++; $display("FAIL flush_gone got %b want 0", hit); end
        ncmp++; if (maddr !== 16'h0100) begin nfail++; $display("FAIL flush_head got %h want 0100", maddr); end
        mem_rdy = 1'b1; tick(); mem_rdy = 1'b0; #3;
        ncmp++; if (empty !== 1'b1) begin nfail++; $display("FAIL flush_count1 got %b want 1", empty); end
        alloc(16'h0103, 16'h0004);
        rob_v = 1'b1; tick(); rob_v = 1'b0; #3;
        ncmp++; if (mdata !== 16'h0004) begin nfail++; $display("FAIL flush_tail got %h want 0004", mdata); end
        mem_rdy = 1'b1; tick(); mem_rdy = 1'b0;
    endtask

    task automatic test_commit_flush();
        idle();
        alloc(16'h0400, 16'hE000);
        alloc(16'h0401, 16'hF000);
        rob_v = 1'b1; mispred = 1'b1; tick(); idle();
        ld_a = 16'h0401; #3;
        ncmp++; if (mvalid !== 1'b1 || maddr !== 16'h0400) begin nfail++; $display("FAIL cflush_survivor got %b/%h want 1/0400", mvalid, maddr); end
        ncmp++; if (hit !== 1'b0) begin nfail++; $display("FAIL cflush_flushed got %b want 0", hit); end
        mem_rdy = 1'b1; tick(); mem_rdy = 1'b0; #3;
        ncmp++; if (empty !== 1'b1) begin nfail++; $display("FAIL cflush_empty got %b want 1", empty); end
    endtask

    task automatic test_reset_mid();
        idle();
        alloc(16'h0500, 16'h0055);
        alloc(16'h0501, 16'h0066);
        rob_v = 1'b1; tick(); tick(); rob_v = 1'b0;
        mem_rdy = 1'b1; ld_a = 16'h0501; #1;
        reset_n = 1'b0; #1;
        ncmp++; if (mvalid !== 1'b0) begin nfail++; $display("FAIL rmid_mvalid got %b want 0", mvalid); end
        ncmp++; if (empty !== 1'b1) begin nfail++; $display("FAIL rmid_empty got %b want 1", empty); end
        ncmp++; if (hit !== 1'b0 || ldata !== 16'h0000) begin nfail++; $display("FAIL rmid_fwd got %b/%h want 0/0000", hit, ldata); end
        ncmp++; if (ready !== 1'b1) begin nfail++; $display("FAIL rmid_ready got %b want 1", ready); end
        idle(); mq.delete(); ncomm = 0;
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            exe_v   = $urandom_range(0, 99) < 60;
            exe_a   = 16'h0040 + 16'($urandom_range(0, 7));
            exe_d   = 16'($urandom);
            rob_v   = $urandom_range(0, 99) < 50;
            mispred = $urandom_range(0, 99) < 4;
            mem_rdy = $urandom_range(0, 99) < 45;
            ld_a    = 16'h0040 + 16'($urandom_range(0, 8));
            #3;
            ncmp++; if (ready !== exp_ready()) begin nfail++; $display("FAIL rnd_ready c%0d got %b want %b", cyc, ready, exp_ready()); end
            ncmp++; if (mvalid !== exp_mvalid()) begin nfail++; $display("FAIL rnd_mvalid c%0d got %b want %b", cyc, mvalid, exp_mvalid()); end
            if (exp_mvalid()) begin
                ncmp++;
                if (maddr !== mq[0].a || mdata !== mq[0].d) begin
                    nfail++; $display("FAIL rnd_drain c%0d got %h/%h want %h/%h", cyc, maddr, mdata, mq[0].a, mq[0].d);
                end
            end
            ncmp++; if (hit !== exp_hit()) begin nfail++; $display("FAIL rnd_hit c%0d got %b want %b", cyc, hit, exp_hit()); end
            ncmp++; if (ldata !== exp_ldata()) begin nfail++; $display("FAIL rnd_ldata c%0d got %h want %h", cyc, ldata, exp_ldata()); end
            ncmp++; if (empty !== (mq.size() == 0)) begin nfail++; $display("FAIL rnd_empty c%0d got %b want %b", cyc, empty, mq.size() == 0); end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_forward();
        test_flush();
        test_commit_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter SB_ENTRY, default 8, meaning entry count (power of two, >=2).
REQ-002 SHALL have parameter WORD_SIZE_P, default 16, meaning address and data width.
REQ-003 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset_n_i  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port exe_sb_valid_i  input  1  execute presents a resolved store, in program order.
REQ-006 SHALL have port exe_sb_addr_i  input  WORD_SIZE_P  store address.
REQ-007 SHALL have port exe_sb_data_i  input  WORD_SIZE_P  store data.
REQ-008 SHALL have port sb_exe_ready_o  output  1  buffer can accept a store.
REQ-009 SHALL have port rob_sb_valid_i  input  1  ROB commits the oldest uncommitted store.
REQ-010 SHALL have port rob_mispredict_i  input  1  ROB flush.
REQ-011 SHALL have port sb_mem_valid_o  output  1  committed store offered to memory.
REQ-012 SHALL have port sb_mem_addr_o  output  WORD_SIZE_P  drain address.
REQ-013 SHALL have port sb_mem_data_o  output  WORD_SIZE_P  drain data.
REQ-014 SHALL have port mem_sb_ready_i  input  1  memory accepts the drain.
REQ-015 SHALL have port ld_addr_i  input  WORD_SIZE_P  load lookup address.
REQ-016 SHALL have port sb_ld_hit_o  output  1  a buffered store matches ld_addr_i.
REQ-017 SHALL have port sb_ld_data_o  output  WORD_SIZE_P  forwarded data.
REQ-018 SHALL have port sb_empty_o  output  1  no valid entries.

Function
REQ-019 SHALL be a circular buffer with registered head (oldest), commit (oldest uncommitted) and tail (next free) pointers of $clog2(SB_ENTRY) bits plus a $clog2(SB_ENTRY)+1-bit count; pointers wrap SB_ENTRY-1 -> 0.
REQ-020 SHALL drive sb_exe_ready_o = (count != SB_ENTRY) & ~rob_mispredict_i, from registered count only (no combinational path from mem_sb_ready_i).
REQ-021 SHALL on exe_sb_valid_i & sb_exe_ready_o write addr/data at tail as valid, uncommitted, and advance tail next edge.
REQ-022 SHALL on rob_sb_valid_i with at least one uncommitted entry mark entry[commit] committed and advance commit; with none, ignore it.
REQ-023 SHALL drive sb_mem_valid_o high iff entry[head] is valid and committed; addr/data from entry[head], stable while valid & ~ready.
REQ-024 SHALL on sb_mem_valid_o & mem_sb_ready_i invalidate entry[head] and advance head next edge.
REQ-025 SHALL on rob_mispredict_i commit any same-cycle rob_sb_valid_i first, then invalidate every uncommitted entry and set tail = resulting commit pointer; committed entries and a same-cycle drain proceed unaffected.
REQ-026 SHALL update count = count + alloc - drain, or on flush to (committed entries remaining after the same-cycle drain).
REQ-027 SHALL permit alloc, commit and drain in one cycle, including a commit of the entry allocated that cycle? No: commit applies only to entries valid at the clock edge before.
REQ-028 SHALL compute sb_ld_hit_o/sb_ld_data_o combinationally over valid entries (committed or not) with exact address equality, returning the youngest match (nearest tail); no match: hit 0, data 0.
REQ-029 SHALL drive sb_empty_o = (count == 0).

Reset
REQ-030 SHALL on reset_n_i low immediately clear all pointers, count, and valid/committed bits; sb_mem_valid_o 0, sb_ld_hit_o 0, sb_ld_data_o 0, sb_empty_o 1, sb_exe_ready_o 1 (absent mispredict).
REQ-031 SHALL discard all contents, including committed stores, if reset asserts mid-operation; release is synchronous to clk_i.

Verification
REQ-032 SHALL cover: alloc {0x0010,0xAAAA}, commit, ready=1 -> sb_mem_valid_o next cycle with 0x0010/0xAAAA, empty after accept.
REQ-033 SHALL cover: 8 allocs with mem_sb_ready_i=0 -> sb_exe_ready_o 0 at count 8; commit+drain one -> ready 1; pointers wrap to 0.
REQ-034 SHALL cover: allocs to 0x0020 data 0x1111 then 0x2222, ld_addr_i=0x0020 -> hit 1, data 0x2222; ld_addr_i=0x0030 -> hit 0, data 0.
REQ-035 SHALL cover: 3 allocs, 1 commit, rob_mispredict_i -> count 1, tail = commit pointer, only first store drains.
REQ-036 SHALL cover: rob_sb_valid_i with mispredict same cycle on 2 uncommitted entries -> first survives committed, second flushed.
REQ-037 SHALL cover: reset_n_i low mid-drain -> outputs to reset values without clock edge.
